// File: rtl/io_input_debounce.sv
// Two-channel switch/key conditioner: 2-flop synchronizers, shared sample tick,
// per-bit debounce, registered 32-bit IO words. Optional macro: DEBOUNCE_EVENT_CNT_EN.
`timescale 1ns/1ps

// Per-bit debounce state, encoded by the stability counter sc:
//   state     | meaning
//   STABLE    | sc == 0, synchronized input agrees with deb
//   COUNTING  | 0 < sc < STABLE_CNT, input disagreed on sc consecutive ticks
//   (flip)    | disagreeing tick with sc == STABLE_CNT-1: deb takes input, back to STABLE
module io_input_debounce #(
   parameter int WIDTH      = 10,
   parameter int TICK_DIV   = 50000,
   parameter int STABLE_CNT = 4
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [WIDTH-1:0] raw0,
   input  logic [WIDTH-1:0] raw1,
   output logic [31:0]      in_port0,
   output logic [31:0]      in_port1,
   output logic             changed
);

   localparam int CH_W = 2 * WIDTH;
   localparam int TD_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SC_W = $clog2(STABLE_CNT + 1);
   localparam logic [TD_W-1:0] TICK_LAST = TD_W'(TICK_DIV - 1);
   localparam logic [TD_W-1:0] TD_ONE    = TD_W'(1);
   localparam logic [SC_W-1:0] SC_LAST   = SC_W'(STABLE_CNT - 1);
   localparam logic [SC_W-1:0] SC_ONE    = SC_W'(1);

   logic [CH_W-1:0] raw_cat;
   logic [CH_W-1:0] sync_meta;
   logic [CH_W-1:0] sync;

   logic [TD_W-1:0] tick_cnt;
   logic [TD_W-1:0] tick_cnt_nxt;
   logic            tick;

   logic [CH_W-1:0]           deb;
   logic [CH_W-1:0]           deb_nxt;
   logic [CH_W-1:0][SC_W-1:0] sc;
   logic [CH_W-1:0][SC_W-1:0] sc_nxt;

   logic [WIDTH-1:0] port0_q;
   logic [WIDTH-1:0] port1_q;
   logic             any_flip;

   // Channel 1 in the upper half so one vector carries both buses.
   assign raw_cat = {raw1, raw0};

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync_meta <= '0;
         sync      <= '0;
      end else begin
         sync_meta <= raw_cat;
         sync      <= sync_meta;
      end
   end

   assign tick         = (tick_cnt == TICK_LAST);
   assign tick_cnt_nxt = tick ? '0 : (tick_cnt + TD_ONE);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt_nxt;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         deb <= '0;
         sc  <= '0;
      end else begin
         deb <= deb_nxt;
         sc  <= sc_nxt;
      end
   end

   always_comb begin
      deb_nxt = deb;
      sc_nxt  = sc;
      if (tick) begin
         for (int i = 0; i < CH_W; i++) begin
            if (sync[i] == deb[i]) begin
               sc_nxt[i] = '0;
            end else if (sc[i] == SC_LAST) begin
               deb_nxt[i] = sync[i];
               sc_nxt[i]  = '0;
            end else begin
               sc_nxt[i] = sc[i] + SC_ONE;
            end
         end
      end
   end

   // The output copy lags deb by one cycle, so a difference is exactly a flip.
   assign any_flip = |(deb ^ {port1_q, port0_q});

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         port0_q <= '0;
         port1_q <= '0;
         changed <= 1'b0;
      end else begin
         port0_q <= deb[WIDTH-1:0];
         port1_q <= deb[CH_W-1:WIDTH];
         changed <= any_flip;
      end
   end

`ifdef DEBOUNCE_EVENT_CNT_EN
   logic [7:0] evt_cnt;
   logic       ch0_flip;

   // Several channel-0 bits flipping on one tick still count as a single event.
   assign ch0_flip = |(deb[WIDTH-1:0] ^ port0_q);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         evt_cnt <= '0;
      end else if (ch0_flip) begin
         evt_cnt <= evt_cnt + 8'd1;
      end
   end

   assign in_port0 = {evt_cnt, 24'(port0_q)};
`else
   assign in_port0 = 32'(port0_q);
`endif

   assign in_port1 = 32'(port1_q);

endmodule

// File: tb/tb_io_input_debounce.sv
// Self-checking bench for io_input_debounce: directed scenarios plus random
// stimulus, every cycle compared against a sample-window reference model.
`timescale 1ns/1ps

module tb_io_input_debounce;

   localparam int W  = 10;
   localparam int TD = 4;
   localparam int SC = 3;

   logic          clock;
   logic          resetn;
   logic [W-1:0]  raw0;
   logic [W-1:0]  raw1;
   logic [31:0]   in_port0;
   logic [31:0]   in_port1;
   logic          changed;

   int n_checks = 0;
   int n_errors = 0;
   int chg_cnt  = 0;
   bit mon_en   = 0;

   io_input_debounce #(
      .WIDTH      (W),
      .TICK_DIV   (TD),
      .STABLE_CNT (SC)
   ) dut (
      .clock    (clock),
      .resetn   (resetn),
      .raw0     (raw0),
      .raw1     (raw1),
      .in_port0 (in_port0),
      .in_port1 (in_port1),
      .changed  (changed)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: raw is seen two edges late; on every TD-th edge after
   // reset the delayed sample joins a window of the last SC tick samples, and
   // a bit takes a new level only when the whole window shows that level.
   logic [W-1:0] h0[$];
   logic [W-1:0] h1[$];
   logic [W-1:0] win0[$];
   logic [W-1:0] win1[$];
   logic [W-1:0] m_deb0, m_deb1, m_port0, m_port1;
   logic         m_changed;
   logic [7:0]   m_evt;
   int           m_edge;

   function automatic logic [W-1:0] accept(input logic [W-1:0] deb, input logic [W-1:0] w[$]);
      logic [W-1:0] all1;
      logic [W-1:0] any1;
      all1 = '1;
      any1 = '0;
      foreach (w[k]) begin
         all1 &= w[k];
         any1 |= w[k];
      end
      return (deb & any1) | all1;
   endfunction

   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         h0 = {}; h1 = {}; win0 = {}; win1 = {};
         repeat (2) begin h0.push_back('0); h1.push_back('0); end
         repeat (SC) begin win0.push_back('0); win1.push_back('0); end
         m_deb0 = '0; m_deb1 = '0; m_port0 = '0; m_port1 = '0;
         m_changed = 1'b0; m_evt = '0; m_edge = 0;
      end else begin
         m_edge++;
         m_changed = (m_deb0 != m_port0) || (m_deb1 != m_port1);
         if (m_deb0 != m_port0) m_evt = m_evt + 8'd1;
         m_port0 = m_deb0;
         m_port1 = m_deb1;
         if (m_edge % TD == 0) begin
            win0.push_back(h0[0]); void'(win0.pop_front());
            win1.push_back(h1[0]); void'(win1.pop_front());
            m_deb0 = accept(m_deb0, win0);
            m_deb1 = accept(m_deb1, win1);
         end
         void'(h0.pop_front()); h0.push_back(raw0);
         void'(h1.pop_front()); h1.push_back(raw1);
      end
   end

   function automatic logic [31:0] exp_p0();
`ifdef DEBOUNCE_EVENT_CNT_EN
      return {m_evt, 14'd0, m_port0};
`else
      return {22'd0, m_port0};
`endif
   endfunction

   always @(negedge clock) begin
      if (mon_en) begin
         check("in_port0", in_port0, exp_p0());
         check("in_port1", in_port1, {22'd0, m_port1});
         check("changed", {31'd0, changed}, {31'd0, m_changed});
         if (changed === 1'b1) chg_cnt++;
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      bit seen;
      resetn = 1'b0;
      raw0   = 10'h3FF;
      raw1   = 10'h3FF;
      step(2);
      mon_en = 1;
      step(4);
      check("rst_port0", in_port0, 32'h0);
      check("rst_port1", in_port1, 32'h0);
      check("rst_changed", {31'd0, changed}, 32'h0);
      raw0 = '0;
      raw1 = '0;
      step(3);

      // Clean step straight after release.
      resetn  = 1'b1;
      raw0    = 10'h001;
      chg_cnt = 0;
      lat     = 0;
      while (in_port0 !== 32'h1 && lat < 40) begin
         step(1);
         lat++;
      end
      check("step_lat_min", {31'd0, lat >= 11}, 32'd1);
      check("step_lat_max", {31'd0, lat <= 15}, 32'd1);
      step(20);
      check("step_port0", in_port0, 32'h1);
      check("step_chg_cnt", chg_cnt, 32'd1);
      check("step_port1", in_port1, 32'h0);

      // Glitch rejection on raw1[5].
      chg_cnt = 0;
      raw1[5] = 1'b1;
      step(5);
      raw1[5] = 1'b0;
      step(30);
      check("glitch_port1", in_port1, 32'h0);
      check("glitch_chg", chg_cnt, 32'd0);
      for (int s = 0; s < 14; s++) begin
         raw1[5] = (s % 2 == 0);
         step(3);
      end
      raw1[5] = 1'b0;
      step(30);
      check("toggle_port1", in_port1, 32'h0);
      check("toggle_chg", chg_cnt, 32'd0);

      // Independent bits: bit 9 steps while bit 0 bounces one cycle in three.
      raw0 = '0;
      step(20);
      check("indep_clear", in_port0, 32'h0);
      seen = 0;
      for (int s = 0; s < 45; s++) begin
         raw0 = (s % 3 == 0) ? 10'h201 : 10'h200;
         step(1);
         if (in_port0[0] === 1'b1) seen = 1;
      end
      raw0 = 10'h200;
      step(20);
      check("indep_port0", in_port0, 32'h200);
      check("indep_bit0", {31'd0, seen}, 32'd0);

      // Reset in the middle of a raw1 step.
      raw0 = '0;
      step(20);
      raw1 = 10'h155;
      step(10);
      #2 resetn = 1'b0;
      #1 check("midrst_port1", in_port1, 32'h0);
      step(3);
      check("midrst_hold", in_port1, 32'h0);
      resetn = 1'b1;
      lat = 0;
      while (in_port1 !== 32'h155 && lat < 40) begin
         step(1);
         lat++;
      end
      check("midrst_lat_max", {31'd0, lat <= 15}, 32'd1);
      check("midrst_port1", in_port1, 32'h155);

      // Random stimulus, checked every cycle by the monitor.
      for (int r = 0; r < 150; r++) begin
         case ($urandom_range(0, 3))
            0: raw0 = raw0 ^ W'($urandom);
            1: raw1 = raw1 ^ W'($urandom);
            2: raw0[$urandom_range(0, W-1)] ^= 1'b1;
            default: begin raw0 = W'($urandom); raw1 = W'($urandom); end
         endcase
         step($urandom_range(1, 20));
      end
      step(20);

`ifdef DEBOUNCE_EVENT_CNT_EN
      #2 resetn = 1'b0;
      raw0 = '0;
      raw1 = '0;
      step(3);
      resetn = 1'b1;
      for (int t = 1; t <= 256; t++) begin
         raw0[0] = ~raw0[0];
         step(20);
         check("evt_low_bits", {22'd0, in_port0[9:0]}, {22'd0, raw0});
         if (t == 1)   check("evt_first", {24'd0, in_port0[31:24]}, 32'h01);
         if (t == 256) check("evt_wrap", {24'd0, in_port0[31:24]}, 32'h00);
      end
`endif

      step(5);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
